// File: rtl/wvl_phase_center_apply.sv
// Applies the shadowed phase-1 center/scale to photon phase events (subtract, Q0.16 scale, clamp).
// 3-cycle latency, 1 event/cycle; an output stall freezes all stages; config loads drain the pipe first.
module wvl_phase_center_apply #(
    parameter int PHASE_W = 16,
    parameter int ID_W    = 12
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        centers_reg,
    input  logic               cfg_update,
    output logic               cfg_loaded,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic [ID_W-1:0]    in_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_wvl,
    output logic [ID_W-1:0]    out_id,
    output logic               out_sat,
    output logic [15:0]        sat_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]                 r_rst_sync;
    logic                       w_rst_n;

    logic signed [PHASE_W-1:0]  r_center;
    logic [15:0]                r_scale;
    logic [15:0]                r_sat_cnt;

    logic                       r_v1;
    logic                       r_v2;
    logic                       r_v3;
    logic signed [PHASE_W:0]    r_diff;
    logic signed [2*PHASE_W+1:0] r_prod;
    logic [ID_W-1:0]            r_id1;
    logic [ID_W-1:0]            r_id2;
    logic [ID_W-1:0]            r_id3;
    logic [15:0]                r_wvl;
    logic                       r_sat;

    logic                       w_stall;
    logic                       w_adv;
    logic                       w_in_ready;
    logic                       w_load;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_pipe_empty;
    logic signed [PHASE_W:0]    w_diff;
    logic signed [2*PHASE_W+1:0] w_prod;
    logic signed [PHASE_W+1:0]  w_q;
    logic                       w_clamp;
    logic [15:0]                w_wvl;

    // Reset asserts asynchronously but releases two clocks later, in step with user_clk.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_stall      = r_v3 & ~out_ready;
    assign w_adv        = ~w_stall;
    assign w_in_fire    = in_valid & w_in_ready;
    assign w_out_fire   = r_v3 & out_ready;
    assign w_pipe_empty = ~(r_v1 | r_v2 | r_v3);

    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = ~w_stall;
                if (cfg_update) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                // A request landing on the load cycle re-arms another drain/load pass.
                w_state_nxt = cfg_update ? ST_DRAIN : ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_center  <= '0;
            r_scale   <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_load) begin
                r_center  <= centers_reg[31:16];
                r_scale   <= centers_reg[15:0];
                r_sat_cnt <= '0;
            end else if (w_out_fire && r_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign w_diff = $signed({in_phase[PHASE_W-1], in_phase}) - $signed({r_center[PHASE_W-1], r_center});
    assign w_prod = r_diff * $signed({1'b0, r_scale});

    // Taking the upper bits of the product is an arithmetic shift by 16 (floor).
    assign w_q     = r_prod[2*PHASE_W+1:16];
    assign w_clamp = (w_q[PHASE_W+1:PHASE_W-1] != 3'b000) && (w_q[PHASE_W+1:PHASE_W-1] != 3'b111);
    assign w_wvl   = !w_clamp ? w_q[15:0] : (w_q[PHASE_W+1] ? 16'h8000 : 16'h7FFF);

    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_diff <= '0;
            r_prod <= '0;
            r_id1  <= '0;
            r_id2  <= '0;
            r_id3  <= '0;
            r_wvl  <= '0;
            r_sat  <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_in_fire;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (w_in_fire) begin
                r_diff <= w_diff;
                r_id1  <= in_id;
            end
            if (r_v1) begin
                r_prod <= w_prod;
                r_id2  <= r_id1;
            end
            if (r_v2) begin
                r_wvl <= w_wvl;
                r_id3 <= r_id2;
                r_sat <= w_clamp;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign cfg_loaded = w_load;
    assign out_valid  = r_v3;
    assign out_wvl    = r_wvl;
    assign out_id     = r_id3;
    assign out_sat    = r_sat;
    assign sat_count  = r_sat_cnt;

endmodule

// File: tb/tb_wvl_phase_center_apply.sv
// Directed bench for wvl_phase_center_apply: basic, saturation, backpressure, config, re-arm, reset.
module tb_wvl_phase_center_apply;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] centers_reg;
    logic        cfg_update;
    logic        cfg_loaded;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_phase;
    logic [11:0] in_id;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_wvl;
    logic [11:0] out_id;
    logic        out_sat;
    logic [15:0] sat_count;

    int vecs = 0;
    int errs = 0;

    logic [15:0] bp_ph [10] = '{16'h0000, 16'h0100, 16'h7FFF, 16'h8000, 16'h1234,
                                16'hFF00, 16'h4000, 16'hC000, 16'h0101, 16'h00FF};

    always #5 user_clk = ~user_clk;

    wvl_phase_center_apply #(.PHASE_W(16), .ID_W(12)) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .centers_reg (centers_reg),
        .cfg_update  (cfg_update),
        .cfg_loaded  (cfg_loaded),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_phase    (in_phase),
        .in_id       (in_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wvl     (out_wvl),
        .out_id      (out_id),
        .out_sat     (out_sat),
        .sat_count   (sat_count)
    );

    // Reference: {sat, wvl} from integer arithmetic on the register word.
    function automatic logic [16:0] model(input logic [15:0] ph, input logic [31:0] cfg);
        longint d;
        longint p;
        longint q;
        logic [15:0] c;
        logic [15:0] sc;
        c  = cfg[31:16];
        sc = cfg[15:0];
        d  = longint'($signed(ph)) - longint'($signed(c));
        p  = d * longint'(sc);
        q  = p >>> 16;
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] word, output logic ok);
        int n;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        centers_reg = word;
        cfg_update  = 1'b1;
        tick();
        cfg_update = 1'b0;
        n = 0;
        while (!cfg_loaded && n < 50) begin
            tick();
            n++;
        end
        ok = cfg_loaded;
        tick();
    endtask

    task automatic run_one(input logic [15:0] ph, input logic [11:0] id, output logic [15:0] w,
                           output logic [11:0] oid, output logic s, output int lat);
        int n;
        in_phase  = ph;
        in_id     = id;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        w   = out_wvl;
        oid = out_id;
        s   = out_sat;
        tick();
    endtask

    task automatic test_reset();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vecs++; if (out_wvl !== 16'h0) begin errs++; $display("FAIL rst_out_wvl got %h want 0000", out_wvl); end
        vecs++; if (out_id !== 12'h0) begin errs++; $display("FAIL rst_out_id got %h want 000", out_id); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL rst_out_sat got %b want 0", out_sat); end
        vecs++; if (sat_count !== 16'h0) begin errs++; $display("FAIL rst_sat_count got %h want 0000", sat_count); end
        vecs++; if (cfg_loaded !== 1'b0) begin errs++; $display("FAIL rst_cfg_loaded got %b want 0", cfg_loaded); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic ok; logic [15:0] w; logic [11:0] id; logic s; int lat;
        do_load(32'h1000_8000, ok);
        vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_load got %b want 1", ok); end
        run_one(16'h3000, 12'd5, w, id, s, lat);
        vecs++; if (w !== 16'h1000) begin errs++; $display("FAIL basic_wvl got %h want 1000", w); end
        vecs++; if (id !== 12'd5) begin errs++; $display("FAIL basic_id got %0d want 5", id); end
        vecs++; if (s !== 1'b0) begin errs++; $display("FAIL basic_sat got %b want 0", s); end
        vecs++; if (lat !== 3) begin errs++; $display("FAIL basic_latency got %0d want 3", lat); end
    endtask

    task automatic test_saturation();
        logic ok; logic [15:0] w; logic [11:0] id; logic s; int lat;
        do_load(32'h8000_FFFF, ok);
        run_one(16'h7FFF, 12'd1, w, id, s, lat);
        vecs++; if ({s, w} !== {1'b1, 16'h7FFF}) begin errs++; $display("FAIL sat_pos got %b/%h want 1/7fff", s, w); end
        vecs++; if (sat_count !== 16'd1) begin errs++; $display("FAIL sat_count1 got %0d want 1", sat_count); end
        run_one(16'h7FFF, 12'd2, w, id, s, lat);
        vecs++; if (sat_count !== 16'd2) begin errs++; $display("FAIL sat_count2 got %0d want 2", sat_count); end
        do_load(32'h7FFF_FFFF, ok);
        vecs++; if (sat_count !== 16'd0) begin errs++; $display("FAIL sat_count_clr got %0d want 0", sat_count); end
        run_one(16'h8000, 12'd3, w, id, s, lat);
        vecs++; if ({s, w} !== {1'b1, 16'h8000}) begin errs++; $display("FAIL sat_neg got %b/%h want 1/8000", s, w); end
        // The reload above cleared the counter, so this is the first clamp since.
        vecs++; if (sat_count !== 16'd1) begin errs++; $display("FAIL sat_count3 got %0d want 1", sat_count); end
        do_load(32'h1234_0000, ok);
        run_one(16'h7FFF, 12'd4, w, id, s, lat);
        vecs++; if ({s, w} !== {1'b0, 16'h0000}) begin errs++; $display("FAIL scale0 got %b/%h want 0/0000", s, w); end
    endtask

    task automatic test_backpressure();
        logic ok; logic [16:0] e; logic [15:0] hw; logic [11:0] hid; logic hs; logic was_stall;
        int sent; int got; int cyc; int extra;
        do_load(32'h0100_4000, ok);
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; hw = '0; hid = '0; hs = 1'b0;
        while (got < 10 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 10);
            in_phase  = bp_ph[sent < 10 ? sent : 0];
            in_id     = 12'(sent + 100);
            #1;
            if (was_stall) begin
                vecs++;
                if ({out_valid, out_wvl, out_id, out_sat} !== {1'b1, hw, hid, hs}) begin
                    errs++; $display("FAIL bp_hold got %b/%h/%0d/%b want 1/%h/%0d/%b", out_valid, out_wvl, out_id, out_sat, hw, hid, hs);
                end
            end
            was_stall = out_valid && !out_ready;
            hw = out_wvl; hid = out_id; hs = out_sat;
            if (out_valid && out_ready) begin
                e = model(bp_ph[got], 32'h0100_4000);
                vecs++;
                if ({out_sat, out_wvl, out_id} !== {e, 12'(got + 100)}) begin
                    errs++; $display("FAIL bp_out%0d got %b/%h/%0d want %b/%h/%0d", got, out_sat, out_wvl, out_id, e[16], e[15:0], got + 100);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vecs++; if (got !== 10) begin errs++; $display("FAIL bp_count got %0d want 10", got); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) extra++;
            tick();
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL bp_extra got %0d want 0", extra); end
    endtask

    task automatic test_config_traffic();
        logic ok; logic [16:0] e;
        logic [31:0] oldw; logic [31:0] neww;
        logic [31:0] ev_cfg [12];
        int sent; int got; int t_cfg; int t_loaded; int n_loaded; int exits; int bad_ready; int exp_sat;
        oldw = 32'h8000_FFFF; neww = 32'h0000_8000;
        do_load(oldw, ok);
        sent = 0; got = 0; t_cfg = -1; t_loaded = -1; n_loaded = 0; exits = 0; bad_ready = 0; exp_sat = 0;
        for (int i = 0; i < 12; i++) ev_cfg[i] = '0;
        for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
            in_valid   = (sent < 12);
            in_phase   = 16'h7000 + 16'(sent * 256);
            in_id      = 12'(sent);
            out_ready  = 1'b1;
            cfg_update = (t_cfg < 0 && sent == 5);
            if (cfg_update) centers_reg = neww;
            #1;
            if (cfg_update) begin
                vecs++; if (sat_count !== 16'(exp_sat)) begin errs++; $display("FAIL cfg_satcnt_pre got %0d want %0d", sat_count, exp_sat); end
            end
            if (cfg_loaded) begin
                n_loaded++;
                if (t_loaded < 0) t_loaded = cyc;
            end
            if (t_cfg >= 0 && cyc > t_cfg && (t_loaded < 0 || cyc == t_loaded) && in_ready) bad_ready++;
            if (t_loaded >= 0 && cyc == t_loaded + 1) begin
                vecs++; if (sat_count !== 16'd0) begin errs++; $display("FAIL cfg_satcnt_post got %0d want 0", sat_count); end
                vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL cfg_ready_back got %b want 1", in_ready); end
            end
            if (out_valid) begin
                e = model(16'h7000 + 16'(got * 256), ev_cfg[got]);
                vecs++;
                if ({out_sat, out_wvl, out_id} !== {e, 12'(got)}) begin
                    errs++; $display("FAIL cfg_out%0d got %b/%h/%0d want %b/%h/%0d", got, out_sat, out_wvl, out_id, e[16], e[15:0], got);
                end
                if (e[16]) exp_sat++;
                if (t_cfg >= 0 && t_loaded < 0 && cyc > t_cfg) exits++;
                got++;
            end
            if (in_valid && in_ready) begin
                ev_cfg[sent] = (t_cfg >= 0) ? neww : oldw;
                sent++;
            end
            if (cfg_update) t_cfg = cyc;
            tick();
        end
        in_valid = 1'b0; cfg_update = 1'b0;
        vecs++; if (got !== 12) begin errs++; $display("FAIL cfg_count got %0d want 12", got); end
        vecs++; if (t_loaded - t_cfg !== 5) begin errs++; $display("FAIL cfg_drain_len got %0d want 5", t_loaded - t_cfg); end
        vecs++; if (n_loaded !== 1) begin errs++; $display("FAIL cfg_pulses got %0d want 1", n_loaded); end
        vecs++; if (exits !== 3) begin errs++; $display("FAIL cfg_exits got %0d want 3", exits); end
        vecs++; if (bad_ready !== 0) begin errs++; $display("FAIL cfg_ready_drain got %0d want 0", bad_ready); end
        vecs++; if (sat_count !== 16'd0) begin errs++; $display("FAIL cfg_satcnt_end got %0d want 0", sat_count); end
    endtask

    task automatic test_rearm();
        logic [15:0] w; logic [11:0] id; logic s; int lat;
        int n; int first; int second;
        n = 0; first = -1; second = -1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            cfg_update = 1'b0;
            if (cyc == 0) begin
                cfg_update  = 1'b1;
                centers_reg = 32'h0000_FFFF;
            end
            if (cfg_loaded) begin
                n++;
                if (n == 1) begin
                    first       = cyc;
                    cfg_update  = 1'b1;
                    centers_reg = 32'h0200_8000;
                end else begin
                    second = cyc;
                end
            end
            tick();
        end
        cfg_update = 1'b0;
        vecs++; if (n !== 2) begin errs++; $display("FAIL rearm_pulses got %0d want 2", n); end
        vecs++; if (first !== 2 || second !== 4) begin errs++; $display("FAIL rearm_cycles got %0d/%0d want 2/4", first, second); end
        run_one(16'h0600, 12'd7, w, id, s, lat);
        vecs++; if ({s, w, id} !== {1'b0, 16'h0200, 12'd7}) begin errs++; $display("FAIL rearm_value got %b/%h/%0d want 0/0200/7", s, w, id); end
    endtask

    task automatic test_reset_midflight();
        logic ok; logic [15:0] w; logic [11:0] id; logic s; int lat; int extra;
        do_load(32'h8000_FFFF, ok);
        run_one(16'h7FFF, 12'd1, w, id, s, lat);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_phase = 16'h7FFF; in_id = 12'd11;
        tick();
        in_id = 12'd12;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vecs++; if ({out_valid, sat_count} !== {1'b1, 16'd1}) begin errs++; $display("FAIL mid_prestate got %b/%0d want 1/1", out_valid, sat_count); end
        #2;
        user_rst_n = 1'b0;
        #1;
        vecs++;
        if ({out_valid, out_wvl, out_id, out_sat, sat_count, cfg_loaded} !== {1'b0, 16'h0, 12'h0, 1'b0, 16'h0, 1'b0}) begin
            errs++; $display("FAIL mid_reset got %b/%h/%h/%b/%h/%b want all zero", out_valid, out_wvl, out_id, out_sat, sat_count, cfg_loaded);
        end
        out_ready = 1'b1;
        @(posedge user_clk);
        #3;
        user_rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL mid_no_emit got %0d want 0", extra); end
        run_one(16'h1234, 12'd9, w, id, s, lat);
        vecs++; if ({s, w, id} !== {1'b0, 16'h0000, 12'd9}) begin errs++; $display("FAIL mid_shadow got %b/%h/%0d want 0/0000/9", s, w, id); end
    endtask

    initial begin
        user_rst_n  = 1'b0;
        centers_reg = '0;
        cfg_update  = 1'b0;
        in_valid    = 1'b0;
        in_phase    = '0;
        in_id       = '0;
        out_ready   = 1'b0;
        repeat (3) tick();
        user_rst_n = 1'b1;
        repeat (3) tick();
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_config_traffic();
        test_rearm();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
